// File: rtl/mul_seq_ctrl.sv
// Shift-add multiply sequencer for the HiLo pair: one multiplier bit per cycle, IDLE -> CALC -> WB.
// Optional feature: define MUL_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier is zero.
module mul_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               mf_req,
  output logic               busy,
  output logic               stall,
  output logic [2*WIDTH-1:0] mul_ans,
  output logic               en_reg,
  output logic               done
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;
  logic [PW-1:0]    mul_ans_q;
  logic             en_reg_q;

  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    res_d;
  logic             last_d;
  logic             skip_d;

`ifdef MUL_EARLY_EXIT_EN
  assign skip_d = (mplier_q == '0);
`else
  assign skip_d = 1'b0;
`endif

  // Magnitudes are unsigned, so the most negative operand maps cleanly onto 2^(WIDTH-1).
  always_comb begin
    abs_a_d = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b_d = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
    acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    res_d   = neg_q ? -acc_d : acc_d;
    last_d  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // NOTE: the datapath registers are reset too, so an aborted product leaves no residue visible
  // on mul_ans and the next operation always starts from a known accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      mul_ans_q <= '0;
      en_reg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          en_reg_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, abs_a_d};
            mplier_q <= abs_b_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (!skip_d) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
          // With a zero multiplier acc_d equals acc_q, so an early exit yields the same product.
          if (skip_d || last_d) begin
            mul_ans_q <= res_d;
            en_reg_q  <= 1'b1;
            state_q   <= WB;
          end
        end
        WB: begin
          en_reg_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          en_reg_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign stall   = busy & (start | mf_req);
  assign mul_ans = mul_ans_q;
  assign en_reg  = en_reg_q;
  assign done    = en_reg_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner products, stall/reset scenarios and random
// operands checked against an arithmetic reference (true product and expected WB cycle).
module tb_mul_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mf_req;
  logic        busy;
  logic        stall;
  logic [63:0] mul_ans;
  logic        en_reg;
  logic        done;

  int          total;
  int          bad;
  logic [63:0] last_ans;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .mf_req    (mf_req),
    .busy      (busy),
    .stall     (stall),
    .mul_ans   (mul_ans),
    .en_reg    (en_reg),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: the start of the following cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_prod(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    pb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(pa * pb);
  endfunction

  // Cycle (relative to the accepting edge) in which en_reg is expected.
  function automatic int model_lat(input logic sg, input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] m;
    int          n;
    m = (sg && b[31]) ? -b : b;
    if (m == 0) return 1;
    n = 0;
    while (m != 0) begin
      m = m >> 1;
      n++;
    end
    return (n + 1 > 32) ? 32 : n + 1;
`else
    return 32 + 0 * int'(sg) + 0 * int'(b[0]);
`endif
  endfunction

  // Called in an IDLE cycle with start and operands already driven; follows the op through WB.
  task automatic track(input int lat, input logic [63:0] exp, input string tag);
    step();
    start     = 1'b0;
    mf_req    = 1'b0;
    src_a     = $urandom;
    src_b     = $urandom;
    signed_op = 1'($urandom);
    for (int c = 0; c <= lat; c++) begin
      #1;
      if (c == 0) check({tag, " hold"}, mul_ans, last_ans);
      check({tag, " busy"}, 64'(busy), 64'(1));
      check({tag, " en_reg"}, 64'(en_reg), 64'(c == lat));
      if (c == lat) begin
        check({tag, " mul_ans"}, mul_ans, exp);
        check({tag, " done"}, 64'(done), 64'(1));
      end
      step();
    end
    #1;
    check({tag, " idle busy"}, 64'(busy), 64'(0));
    check({tag, " idle en_reg"}, 64'(en_reg), 64'(0));
    last_ans = exp;
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic with_mf, input string tag);
    start     = 1'b1;
    signed_op = sg;
    src_a     = a;
    src_b     = b;
    mf_req    = with_mf;
    #1;
    check({tag, " issue stall"}, 64'(stall), 64'(0));
    track(model_lat(sg, b), exp, tag);
  endtask

  initial begin
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;
    logic        sg;
    total     = 0;
    bad       = 0;
    last_ans  = '0;
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    src_a     = '0;
    src_b     = '0;
    mf_req    = 1'b0;
    repeat (3) step();
    check("rst busy", 64'(busy), 64'(0));
    check("rst stall", 64'(stall), 64'(0));
    check("rst en_reg", 64'(en_reg), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst mul_ans", mul_ans, 64'h0);
    reset = 1'b0;
    step();
    mf_req = 1'b1;
    #1;
    check("idle mf stall", 64'(stall), 64'(0));
    mf_req = 1'b0;

    // Directed products from the corner cases.
    run_op(1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, "multu 3*5");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "multu max*max");
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, "mult -1*-1");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, "mult min*-1");
    run_op(1'b1, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mult -3*7");
    run_op(1'b0, 32'd9, 32'd0, 64'h0, 1'b0, "multu 9*0");
    run_op(1'b0, 32'd9, 32'd1, 64'h9, 1'b0, "multu 9*1");
    run_op(1'b1, 32'd2, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "mult 2*-1");
    // start and mf_req together while idle: no stall, start accepted.
    run_op(1'b1, 32'h1234_5678, 32'h8765_4321,
           model_prod(1'b1, 32'h1234_5678, 32'h8765_4321), 1'b1, "start+mf idle");

    // start held while busy: stalled, ignored, then accepted once idle.
    a1 = $urandom;
    b1 = $urandom | 32'h8000_0000;
    a2 = $urandom;
    b2 = $urandom | 32'h8000_0000;
    start = 1'b1; signed_op = 1'b0; src_a = a1; src_b = b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      if (c == 5) begin
        start = 1'b1; signed_op = 1'b0; src_a = a2; src_b = b2;
      end
      #1;
      check("held start stall", 64'(stall), 64'(c >= 5));
      if (c == 32) begin
        check("held start en_reg", 64'(en_reg), 64'(1));
        check("held start first ans", mul_ans, model_prod(1'b0, a1, b1));
      end
      step();
    end
    last_ans = model_prod(1'b0, a1, b1);
    #1;
    check("held start idle stall", 64'(stall), 64'(0));
    check("held start idle busy", 64'(busy), 64'(0));
    track(32, model_prod(1'b0, a2, b2), "held start second");

    // mf_req during a multiply: stalled through WB, released once idle.
    a1 = $urandom;
    b1 = $urandom | 32'h8000_0000;
    start = 1'b1; signed_op = 1'b1; src_a = a1; src_b = b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= 33; c++) begin
      mf_req = (c >= 10);
      #1;
      check("mf_req stall", 64'(stall), 64'(c >= 10 && c <= 32));
      if (c == 32) check("mf_req ans", mul_ans, model_prod(1'b1, a1, b1));
      step();
    end
    mf_req   = 1'b0;
    last_ans = model_prod(1'b1, a1, b1);

    // Reset mid-CALC aborts with no write pulse.
    start = 1'b1; signed_op = 1'b0; src_a = $urandom; src_b = $urandom | 32'h8000_0000;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort en_reg", 64'(en_reg), 64'(0));
    check("abort mul_ans", mul_ans, 64'h0);
    last_ans = '0;
    step();
    check("abort cyc11 en_reg", 64'(en_reg), 64'(0));
    step();
    reset = 1'b0;
    a1 = $urandom;
    b1 = $urandom;
    run_op(1'b0, a1, b1, model_prod(1'b0, a1, b1), 1'b0, "after abort");

    // Random operands, including short multipliers for the data-dependent exit.
    for (int i = 0; i < 12; i++) begin
      sg = 1'($urandom);
      a1 = $urandom;
      b1 = (i % 3 == 0) ? ($urandom >> $urandom_range(31, 20)) : $urandom;
      run_op(sg, a1, b1, model_prod(sg, a1, b1), 1'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
